// File: rtl/if_pkg.sv
// Shared constants and FSM state type for the instruction-fetch stage.
package if_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
interface if_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: flush (bubble) > hold (keep) > load (capture) > bubble.
module if_id_reg
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic        hold,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_instr,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        valid
);

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (hold) begin
      pc    <= pc;
      instr <= instr;
      valid <= valid;
    end else if (load) begin
      pc    <= fetch_pc;
      instr <= fetch_instr;
      valid <= 1'b1;
    end else begin
      // A bubble keeps the last pc so downstream debug still sees where fetch stalled.
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC sequencing, branch redirect with drain of an in-flight fetch.
// Optional performance counters (stall_cnt, flush_cnt) are built when IF_PERF_CNT_EN is defined.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  if_stage_if.master  imem,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  state_e      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] target, target_next;
  logic        reg_load, reg_flush, reg_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= BOOT;
      pc     <= RESET_PC;
      target <= '0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      target <= target_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    target_next = target;
    reg_load    = 1'b0;
    reg_flush   = 1'b0;
    reg_hold    = 1'b0;
    unique case (state)
      BOOT: begin
        state_next = FETCH;
        reg_flush  = branch_taken;
        reg_hold   = !if_id_write;
        if (branch_taken) pc_next = branch_target;
      end
      FETCH: begin
        if (branch_taken) begin
          reg_flush = 1'b1;
          if (imem.imem_ready) begin
            pc_next = branch_target;
          end else begin
            // The outstanding request must complete at the old address before redirecting.
            target_next = branch_target;
            state_next  = DRAIN;
          end
        end else begin
          reg_hold = !if_id_write;
          reg_load = imem.imem_ready && pc_write;
          if (reg_load && if_id_write) pc_next = pc + PC_INC;
        end
      end
      DRAIN: begin
        reg_flush = 1'b1;
        if (branch_taken) target_next = branch_target;
        if (imem.imem_ready) begin
          pc_next    = branch_taken ? branch_target : target;
          state_next = FETCH;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  assign imem.imem_req  = (state != BOOT);
  assign imem.imem_addr = pc;

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .load        (reg_load),
    .flush       (reg_flush),
    .hold        (reg_hold),
    .fetch_pc    (pc),
    .fetch_instr (imem.imem_rdata),
    .pc          (if_id_pc),
    .instr       (if_id_instr),
    .valid       (if_id_valid)
  );

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write)    stall_cnt <= stall_cnt + 32'd1;
      if (branch_taken) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios with literal expectations plus a randomized run
// compared every cycle against a behavioural fetch model.
module tb_if_stage;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write, if_id_write, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_id_pc, if_id_instr;
  logic        if_id_valid;
  logic [31:0] if_id_pc2, if_id_instr2;
  logic        if_id_valid2;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, stall_cnt2, flush_cnt2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  if_stage_if bus ();
  if_stage_if bus2 ();

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_rdata  = mem_fn(bus.imem_addr);
  assign bus2.imem_rdata = mem_fn(bus2.imem_addr);
  assign bus2.imem_ready = 1'b1;

  if_stage dut (
    .clk (clk), .rst (rst), .pc_write (pc_write), .if_id_write (if_id_write),
    .branch_taken (branch_taken), .branch_target (branch_target), .imem (bus),
    .if_id_pc (if_id_pc), .if_id_instr (if_id_instr), .if_id_valid (if_id_valid)
`ifdef IF_PERF_CNT_EN
    , .stall_cnt (stall_cnt), .flush_cnt (flush_cnt)
`endif
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk (clk), .rst (rst), .pc_write (1'b1), .if_id_write (1'b1),
    .branch_taken (1'b0), .branch_target (32'h0), .imem (bus2),
    .if_id_pc (if_id_pc2), .if_id_instr (if_id_instr2), .if_id_valid (if_id_valid2)
`ifdef IF_PERF_CNT_EN
    , .stall_cnt (stall_cnt2), .flush_cnt (flush_cnt2)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a fetch pointer, an optional pending redirect, and the IF/ID contents.
  logic [31:0] m_pc, m_tgt, m_id_pc, m_id_instr;
  logic        m_id_valid, m_boot, m_drain;
  logic [31:0] m_stall, m_flush;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 32'h0; m_tgt = 32'h0; m_boot = 1'b1; m_drain = 1'b0;
      m_id_pc = 32'h0; m_id_instr = NOP_INSTR; m_id_valid = 1'b0;
      m_stall = 32'h0; m_flush = 32'h0;
    end else begin
      if (!pc_write) m_stall = m_stall + 1;
      if (branch_taken) m_flush = m_flush + 1;
      if (m_boot) begin
        m_boot = 1'b0;
        if (branch_taken) begin
          m_pc = branch_target; m_id_instr = NOP_INSTR; m_id_valid = 1'b0;
        end else if (if_id_write) begin
          m_id_instr = NOP_INSTR; m_id_valid = 1'b0;
        end
      end else if (m_drain) begin
        m_id_instr = NOP_INSTR; m_id_valid = 1'b0;
        if (bus.imem_ready) begin
          m_pc = branch_taken ? branch_target : m_tgt;
          m_drain = 1'b0;
        end else if (branch_taken) begin
          m_tgt = branch_target;
        end
      end else if (branch_taken) begin
        m_id_instr = NOP_INSTR; m_id_valid = 1'b0;
        if (bus.imem_ready) m_pc = branch_target;
        else begin m_tgt = branch_target; m_drain = 1'b1; end
      end else if (if_id_write) begin
        if (bus.imem_ready && pc_write) begin
          m_id_pc = m_pc; m_id_instr = mem_fn(m_pc); m_id_valid = 1'b1;
          m_pc = m_pc + 32'd4;
        end else begin
          m_id_instr = NOP_INSTR; m_id_valid = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      check("cmp imem_req", {31'h0, bus.imem_req}, {31'h0, !m_boot});
      check("cmp imem_addr", bus.imem_addr, m_pc);
      check("cmp if_id_pc", if_id_pc, m_id_pc);
      check("cmp if_id_instr", if_id_instr, m_id_instr);
      check("cmp if_id_valid", {31'h0, if_id_valid}, {31'h0, m_id_valid});
`ifdef IF_PERF_CNT_EN
      check("cmp stall_cnt", stall_cnt, m_stall);
      check("cmp flush_cnt", flush_cnt, m_flush);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic rdy, input logic pw, input logic iw, input logic br, input logic [31:0] tg);
    bus.imem_ready = rdy; pc_write = pw; if_id_write = iw; branch_taken = br; branch_target = tg;
  endtask

  task automatic expect_out(input string name, input logic [31:0] addr, input logic [31:0] id_pc,
                            input logic [31:0] id_instr, input logic id_valid);
    check({name, " addr"}, bus.imem_addr, addr);
    check({name, " id_pc"}, if_id_pc, id_pc);
    check({name, " id_instr"}, if_id_instr, id_instr);
    check({name, " id_valid"}, {31'h0, if_id_valid}, {31'h0, id_valid});
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    #1 rst = 1'b1;
    #1;
    check("reset req", {31'h0, bus.imem_req}, 32'h0);
    expect_out("reset", 32'h0, 32'h0, NOP_INSTR, 1'b0);
    check("reset dut2 addr", bus2.imem_addr, 32'hFFFF_FFFC);
`ifdef IF_PERF_CNT_EN
    check("reset dut2 cnt", stall_cnt2 | flush_cnt2, 32'h0);
`endif
    tick(); tick();
    rst = 1'b0;
    check("boot req", {31'h0, bus.imem_req}, 32'h0);

    // Free-running fetch from reset
    tick();
    check("fetch req", {31'h0, bus.imem_req}, 32'h1);
    expect_out("first fetch", 32'h0, 32'h0, NOP_INSTR, 1'b0);
    check("dut2 first addr", bus2.imem_addr, 32'hFFFF_FFFC);
    tick();
    expect_out("seq0", 32'h4, 32'h0, mem_fn(32'h0), 1'b1);
    check("dut2 wrap addr", bus2.imem_addr, 32'h0);
    check("dut2 id_pc", if_id_pc2, 32'hFFFF_FFFC);
    check("dut2 id_valid", {31'h0, if_id_valid2}, 32'h1);
    check("dut2 id_instr", if_id_instr2, mem_fn(32'hFFFF_FFFC));
    tick();
    expect_out("seq1", 32'h8, 32'h4, mem_fn(32'h4), 1'b1);
    check("model pc seq1", m_pc, 32'h8);

    // Memory wait states at pc=8
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("wait", 32'h8, 32'h4, NOP_INSTR, 1'b0);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    expect_out("after wait", 32'hC, 32'h8, mem_fn(32'h8), 1'b1);
    tick();
    expect_out("seq C", 32'h10, 32'hC, mem_fn(32'hC), 1'b1);

    // Hazard stall at pc=0x10
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      expect_out("stall", 32'h10, 32'hC, mem_fn(32'hC), 1'b1);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    expect_out("resume", 32'h14, 32'h10, mem_fn(32'h10), 1'b1);

    // Branch while the fetch is still outstanding
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
    tick();
    expect_out("branch drain", 32'h14, 32'h10, NOP_INSTR, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      expect_out("drain wait", 32'h14, 32'h10, NOP_INSTR, 1'b0);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    expect_out("drain done", 32'h100, 32'h10, NOP_INSTR, 1'b0);
    tick();
    expect_out("target fetch", 32'h104, 32'h100, mem_fn(32'h100), 1'b1);

    // Newest redirect wins during drain
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
    tick();
    check("second branch addr", bus.imem_addr, 32'h104);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    expect_out("newest target", 32'h200, 32'h100, NOP_INSTR, 1'b0);
    tick();
    expect_out("fetch 200", 32'h204, 32'h200, mem_fn(32'h200), 1'b1);
    check("model pc 204", m_pc, 32'h204);

    // Reset in the middle of a drain abandons the redirect
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h300);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    check("mid-drain reset req", {31'h0, bus.imem_req}, 32'h0);
    expect_out("mid-drain reset", 32'h0, 32'h0, NOP_INSTR, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    expect_out("post reset", 32'h0, 32'h0, NOP_INSTR, 1'b0);
    tick();
    expect_out("post reset fetch", 32'h4, 32'h0, mem_fn(32'h0), 1'b1);

`ifdef IF_PERF_CNT_EN
    check("perf zero stall", stall_cnt, 32'h0);
    check("perf zero flush", flush_cnt, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
    tick(); tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    check("perf stall_cnt", stall_cnt, 32'd5);
    check("perf flush_cnt", flush_cnt, 32'd2);
`endif

    // Randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
            $urandom_range(0, 9) == 0, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
